tcm_mem_ram_param: RTL



---
 rtl/tcm_mem_ram_param.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tcm_mem_ram_param.sv
// Dual-port byte-writable tightly-coupled RAM with zero-fill on reset.
// Optional output register, selectable same-port read-during-write.
module tcm_mem_ram_param #(
  parameter int DATA_W         = 64,
  parameter int DEPTH          = 16384,
  parameter int READ_MODE      = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_i,
  input  logic [ADDR_W-1:0]     addr0_i,
  input  logic [DATA_W-1:0]     data0_i,
  input  logic [DATA_W/8-1:0]   wr0_i,
  output logic [DATA_W-1:0]     data0_o,
  output logic                  valid0_o,
  input  logic                  req1_i,
  input  logic [ADDR_W-1:0]     addr1_i,
  input  logic [DATA_W-1:0]     data1_i,
  input  logic [DATA_W/8-1:0]   wr1_i,
  output logic [DATA_W-1:0]     data1_o,
  output logic                  valid1_o,
  output logic                  ready_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEPTH);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]       state_q;
  logic [CNT_W-1:0] init_cnt;
  logic             ready;
  logic             acc0;
  logic             acc1;
  logic             clr_en;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic             v0_q;
  logic             v1_q;
  logic [DATA_W-1:0] d0_q;
  logic [DATA_W-1:0] d1_q;

  assign ready   = (state_q == S_RUN);
  assign ready_o = ready;
  assign acc0    = req0_i & ready;
  assign acc1    = req1_i & ready;
  // The counter runs one past DEPTH-1 so RUN starts the edge after the last fill write.
  assign clr_en  = (state_q == S_INIT) && (CLEAR_ON_RESET != 0)
                && (init_cnt != CNT_END);

  // INIT/RUN sequencing and zero-fill address counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_INIT;
      init_cnt <= '0;
    end else begin
      unique case (1'b1)
        (state_q == S_INIT): begin
          if (CLEAR_ON_RESET == 0 || init_cnt == CNT_END)
            state_q <= S_RUN;
          else
            init_cnt <= init_cnt + 1'b1;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Array writes; port 0 is applied last so it wins a shared byte lane
  always_ff @(posedge clk_i) begin
    if (clr_en)
      mem[init_cnt[ADDR_W-1:0]] <= '0;
    for (int k = 0; k < BYTES; k++)
      if (acc1 && wr1_i[k])
        mem[addr1_i][8*k +: 8] <= data1_i[8*k +: 8];
    for (int k = 0; k < BYTES; k++)
      if (acc0 && wr0_i[k])
        mem[addr0_i][8*k +: 8] <= data0_i[8*k +: 8];
  end

  // Pre-write word, optionally merged with this port's own write bytes
  always_comb begin
    rd0 = mem[addr0_i];
    rd1 = mem[addr1_i];
    if (READ_MODE == 1) begin
      for (int k = 0; k < BYTES; k++) begin
        if (wr0_i[k]) rd0[8*k +: 8] = data0_i[8*k +: 8];
        if (wr1_i[k]) rd1[8*k +: 8] = data1_i[8*k +: 8];
      end
    end
  end

  // First read stage; data only moves on an accepted request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      v0_q <= acc0;
      v1_q <= acc1;
      if (acc0) d0_q <= rd0;
      if (acc1) d1_q <= rd1;
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic             v0_r;
      logic             v1_r;
      logic [DATA_W-1:0] d0_r;
      logic [DATA_W-1:0] d1_r;

      // Extra output stage, holding data between pulses
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v0_r <= 1'b0;
          v1_r <= 1'b0;
          d0_r <= '0;
          d1_r <= '0;
        end else begin
          v0_r <= v0_q;
          v1_r <= v1_q;
          if (v0_q) d0_r <= d0_q;
          if (v1_q) d1_r <= d1_q;
        end
      end

      assign valid0_o = v0_r;
      assign valid1_o = v1_r;
      assign data0_o  = d0_r;
      assign data1_o  = d1_r;
    end else begin : g_no_out_reg
      assign valid0_o = v0_q;
      assign valid1_o = v1_q;
      assign data0_o  = d0_q;
      assign data1_o  = d1_q;
    end
  endgenerate

endmodule
